// File: rtl/acc_pkg.sv
// acc_pkg: opcodes, FSM state encoding and shift-counter width shared by the accumulator stage
package acc_pkg;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XNR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_INC = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
endpackage

// File: rtl/acc_alu.sv
// acc_alu: combinational next-AC and next-carry for the single-cycle accumulator ops
module acc_alu import acc_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_ac,
  input  logic [WIDTH-1:0] i_mem,
  input  logic [WIDTH-1:0] i_xnr,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_ac,
  output logic             o_carry
);
  logic [WIDTH:0] w_sum;
  // NOP and SHL fall through unchanged; SHL is sequenced by the FSM
  always_comb begin
    w_sum = {1'b0, i_ac} + {1'b0, i_mem};
    o_ac = i_op == OP_LDA ? i_mem :
           i_op == OP_ADD ? w_sum[WIDTH-1:0] :
           i_op == OP_AND ? (i_ac & i_mem) :
           i_op == OP_XNR ? i_xnr :
           i_op == OP_INC ? i_ac + 1'b1 :
           i_op == OP_CLR ? '0 : i_ac;
    o_carry = i_op == OP_ADD ? w_sum[WIDTH] : i_op == OP_CLR ? 1'b0 : i_carry;
  end
endmodule

// File: rtl/acc_unit.sv
// acc_unit: AC register stage with start/done handshake; ACC_SHIFT_EN builds the multi-cycle SHL
module acc_unit import acc_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] xnor_result,
  output logic [WIDTH-1:0] ac,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);
  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_mem, r_xnr, r_ac;
  logic             r_zero, r_carry, r_busy, r_done;
  logic [WIDTH-1:0] w_ac;
  logic             w_carry;
`ifdef ACC_SHIFT_EN
  logic [CNT_W-1:0] r_cnt;
`endif
  acc_alu #(.WIDTH(WIDTH)) u_alu (
    .i_op(r_op), .i_ac(r_ac), .i_mem(r_mem), .i_xnr(r_xnr), .i_carry(r_carry),
    .o_ac(w_ac), .o_carry(w_carry)
  );
  // control FSM; operands are latched at start so later input changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op <= OP_NOP;
      r_mem <= '0;
      r_xnr <= '0;
      r_ac <= '0;
      r_zero <= 1'b1;
      r_carry <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef ACC_SHIFT_EN
      r_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_op <= opcode;
          r_mem <= mem_data;
          r_xnr <= xnor_result;
          r_busy <= 1'b1;
          r_state <= EXEC;
        end
        EXEC: begin
`ifdef ACC_SHIFT_EN
          if (r_op == OP_SHL && r_mem[CNT_W-1:0] != '0) begin
            r_cnt <= r_mem[CNT_W-1:0];
            r_state <= SHIFT;
          end else
`endif
          begin
            r_ac <= w_ac;
            r_zero <= w_ac == '0;
            r_carry <= w_carry;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_state <= DONE;
          end
        end
`ifdef ACC_SHIFT_EN
        SHIFT: begin
          {r_carry, r_ac} <= {r_ac, 1'b0};
          r_zero <= r_ac[WIDTH-2:0] == '0;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_state <= DONE;
          end
        end
`endif
        DONE: begin
          r_done <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ac = r_ac;
  assign zero = r_zero;
  assign carry = r_carry;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed table-driven bench for acc_unit plus multi-cycle corner sequences
module tb_acc_unit;
  import acc_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [7:0] mem_data = 8'h00, xnor_result = 8'h00;
  logic [7:0] ac;
  logic       zero, carry, busy, done;
  int checks = 0, failures = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] m;
    logic [7:0] x;
    logic [7:0] eac;
    logic       ez;
    logic       ec;
  } vec_t;
  vec_t vt[14];

  always #5 clk = ~clk;

  acc_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .mem_data(mem_data),
    .xnor_result(xnor_result), .ac(ac), .zero(zero), .carry(carry), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // lat = edges after the sampling edge until done is visible; busy_n = cycles with busy high
  task automatic run_op(input logic [2:0] op, input logic [7:0] m, input logic [7:0] x,
                        output int lat, output int busy_n);
    @(negedge clk);
    opcode = op; mem_data = m; xnor_result = x; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; opcode = ~op; mem_data = ~m; xnor_result = ~x;
    lat = -1; busy_n = 0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) lat = c - 1;
    end
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  task automatic op_check(input string name, input logic [2:0] op, input logic [7:0] m,
                          input logic [7:0] x, input logic [7:0] eac, input logic ez,
                          input logic ec, input int elat, input int ebusy);
    int lat, bn;
    run_op(op, m, x, lat, bn);
    check({name, "_ac"}, ac, eac);
    check({name, "_zero"}, zero, ez);
    check({name, "_carry"}, carry, ec);
    check({name, "_lat"}, lat, elat);
    check({name, "_busy"}, bn, ebusy);
  endtask

  initial begin
    int ndone;
    logic [7:0] sv_ac;
    vt[0]  = '{OP_LDA, 8'h95, 8'h33, 8'h95, 1'b0, 1'b0};
    vt[1]  = '{OP_XNR, 8'h8A, 8'hE0, 8'hE0, 1'b0, 1'b0};
    vt[2]  = '{OP_LDA, 8'hF0, 8'h00, 8'hF0, 1'b0, 1'b0};
    vt[3]  = '{OP_ADD, 8'h20, 8'h00, 8'h10, 1'b0, 1'b1};
    vt[4]  = '{OP_LDA, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1};
    vt[5]  = '{OP_INC, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[6]  = '{OP_LDA, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b1};
    vt[7]  = '{OP_AND, 8'h0F, 8'hFF, 8'h0C, 1'b0, 1'b1};
    vt[8]  = '{OP_NOP, 8'h77, 8'h77, 8'h0C, 1'b0, 1'b1};
    vt[9]  = '{OP_CLR, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0};
    vt[10] = '{OP_LDA, 8'h7F, 8'h00, 8'h7F, 1'b0, 1'b0};
    vt[11] = '{OP_ADD, 8'h01, 8'h00, 8'h80, 1'b0, 1'b0};
    vt[12] = '{OP_ADD, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[13] = '{OP_INC, 8'hAA, 8'h00, 8'h01, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ac", ac, 8'h00);
    check("rst_zero", zero, 1);
    check("rst_carry", carry, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    for (int i = 0; i < 14; i++)
      op_check($sformatf("vec%0d", i), vt[i].op, vt[i].m, vt[i].x, vt[i].eac, vt[i].ez, vt[i].ec, 1, 1);

    op_check("lda81", OP_LDA, 8'h81, 8'h00, 8'h81, 1'b0, 1'b1, 1, 1);
`ifdef ACC_SHIFT_EN
    op_check("shl3", OP_SHL, 8'h03, 8'h00, 8'h08, 1'b0, 1'b0, 4, 4);
    op_check("shl0", OP_SHL, 8'h08, 8'h00, 8'h08, 1'b0, 1'b0, 1, 1);
`else
    op_check("shl_nop", OP_SHL, 8'h03, 8'h00, 8'h81, 1'b0, 1'b1, 1, 1);
    op_check("shl0_nop", OP_SHL, 8'h08, 8'h00, 8'h81, 1'b0, 1'b1, 1, 1);
`endif

    // start held high with LDA 0x55 while the op is in flight must be ignored
    sv_ac = ac;
    @(negedge clk);
    opcode = OP_SHL; mem_data = 8'h02; xnor_result = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    opcode = OP_LDA; mem_data = 8'h55; xnor_result = 8'h55;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("ign_ndone", ndone, 1);
    check("ign_not55", ac == 8'h55, 0);
`ifdef ACC_SHIFT_EN
    check("ign_ac", ac, {sv_ac[5:0], 2'b00});
`else
    check("ign_ac", ac, sv_ac);
`endif

    // reset in the middle of an op: no write-back, no done pulse
    op_check("pre_lda", OP_LDA, 8'hF0, 8'h00, 8'hF0, 1'b0, carry, 1, 1);
    op_check("pre_add", OP_ADD, 8'h20, 8'h00, 8'h10, 1'b0, 1'b1, 1, 1);
    @(negedge clk);
`ifdef ACC_SHIFT_EN
    opcode = OP_SHL; mem_data = 8'h07;
`else
    opcode = OP_ADD; mem_data = 8'hFF;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef ACC_SHIFT_EN
    repeat (3) @(negedge clk);
`else
    @(negedge clk);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ac", ac, 8'h00);
    check("mid_rst_zero", zero, 1);
    check("mid_rst_carry", carry, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_nodone", ndone, 0);
    op_check("post_rst", OP_LDA, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
